// File: rtl/mem_read_streamer_if.sv
// rtl/mem_read_streamer_if.sv - command, memory read port and output stream bundle for mem_read_streamer (MEM_STREAM_STRIDE_EN adds stride)
`timescale 1ns/1ps
interface mem_read_streamer_if #(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
);
  logic                start;
  logic [DEPTH-1:0]    base_addr;
  logic [DEPTH:0]      length;
`ifdef MEM_STREAM_STRIDE_EN
  logic [DEPTH-1:0]    stride;
`endif
  logic [DEPTH-1:0]    read_addr;
  logic [BIT_SIZE-1:0] read_data;
  logic [BIT_SIZE-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;

  // master: command issuer, memory and downstream sink; slave: the streamer
  modport master (
`ifdef MEM_STREAM_STRIDE_EN
    output stride,
`endif
    output start, base_addr, length, read_data, out_ready,
    input  read_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
`ifdef MEM_STREAM_STRIDE_EN
    input  stride,
`endif
    input  start, base_addr, length, read_data, out_ready,
    output read_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/mem_read_streamer.sv
// rtl/mem_read_streamer.sv - walks a memory region and streams words with valid/ready/last
// Optional MEM_STREAM_STRIDE_EN: per-command address stride instead of a fixed +1 step.
`timescale 1ns/1ps
module mem_read_streamer #(
  parameter int DEPTH    = 8,
  parameter int BIT_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_read_streamer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    addr_q, addr_d;
  logic [DEPTH:0]      rem_q, rem_d;
  logic [BIT_SIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [DEPTH-1:0]    step;
  logic                load;

`ifdef MEM_STREAM_STRIDE_EN
  logic [DEPTH-1:0]    stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = {{(DEPTH-1){1'b0}}, 1'b1};
`endif

  // The output stage may be refilled in the same cycle its word is accepted.
  assign load = (state_q == STREAM) && (rem_q != '0) && (!valid_q || bus.out_ready);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef MEM_STREAM_STRIDE_EN
    stride_d = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            addr_d  = bus.base_addr;
            rem_d   = bus.length;
            state_d = STREAM;
`ifdef MEM_STREAM_STRIDE_EN
            stride_d = bus.stride;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (load) begin
          data_d  = bus.read_data;
          valid_d = 1'b1;
          last_d  = (rem_q == {{DEPTH{1'b0}}, 1'b1});
          addr_d  = addr_q + step;
          rem_d   = rem_q - {{DEPTH{1'b0}}, 1'b1};
          if (rem_q == {{DEPTH{1'b0}}, 1'b1}) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_STREAM_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef MEM_STREAM_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign bus.read_addr = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_read_streamer.sv
// tb/tb_mem_read_streamer.sv - directed bench with a queue-based stream model for mem_read_streamer
`timescale 1ns/1ps
module tb_mem_read_streamer;
  localparam int DEPTH = 8;
  localparam int BW    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_read_streamer_if #(.DEPTH(DEPTH), .BIT_SIZE(BW)) bus ();
  mem_read_streamer #(.DEPTH(DEPTH), .BIT_SIZE(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [BW-1:0] mem [0:255];
  assign bus.read_data = mem[bus.read_addr];

  int ncheck = 0;
  int nerr   = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncheck++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // out_ready driver: level or repeating 1,0,0,1,0,1 pattern
  bit rdy_toggle = 1'b0;
  bit rdy_level  = 1'b1;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int pidx = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) begin
      bus.out_ready = pat[pidx];
      pidx = (pidx + 1) % 6;
    end else begin
      bus.out_ready = rdy_level;
    end
  end

  // Model: a command is a list of expected words; busy spans acceptance to last handshake.
  bit            exp_busy = 1'b0;
  bit            exp_done = 1'b0;
  logic [BW-1:0] exp_q [$];
  int            cmd_stride = 1;
  int            done_cnt, done_cyc, first_valid_cyc, beats;
  bit            busy_seen;
  logic [BW-1:0] cap_d [$];
  bit            cap_l [$];
  bit            prev_hold = 1'b0;
  logic [BW-1:0] prev_data;
  logic          prev_last;
  logic [7:0]    prev_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      bit nb;
      bit nd;
      int a;
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (!exp_busy) chk("idle_valid", 32'(bus.out_valid), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
        chk("hold_last", 32'(bus.out_last), 32'(prev_last));
        chk("hold_addr", 32'(bus.read_addr), 32'(prev_addr));
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      nb = exp_busy;
      nd = 1'b0;
      if (!exp_busy) begin
        if (bus.start) begin
          if (bus.length != 0) begin
            nb = 1'b1;
            for (int i = 0; i < int'(bus.length); i++) begin
              a = (int'(bus.base_addr) + i * cmd_stride) & 255;
              exp_q.push_back(mem[a]);
            end
          end else begin
            nd = 1'b1;
          end
        end
      end else if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          chk("beat_data", 32'(bus.out_data), 32'(exp_q[0]));
          chk("beat_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
          void'(exp_q.pop_front());
          cap_d.push_back(bus.out_data);
          cap_l.push_back(bus.out_last);
          beats++;
          if (exp_q.size() == 0) begin
            nb = 1'b0;
            nd = 1'b1;
          end
        end
      end
      exp_busy  = nb;
      exp_done  = nd;
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      prev_addr = bus.read_addr;
    end
  end

  task automatic clear_stats();
    done_cnt        = 0;
    done_cyc        = -1;
    first_valid_cyc = -1;
    beats           = 0;
    busy_seen       = 1'b0;
    cap_d.delete();
    cap_l.delete();
  endtask

  task automatic issue(input int base, input int len, input int stride);
    cmd_stride    = stride;
    bus.start     = 1'b1;
    bus.base_addr = base[7:0];
    bus.length    = len[8:0];
`ifdef MEM_STREAM_STRIDE_EN
    bus.stride    = stride[7:0];
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_words(input string name, input int first, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] e [3];
    e = '{w0, w1, w2};
    for (int i = 0; i < 3; i++) begin
      if (first + i < cap_d.size()) chk(name, 32'(cap_d[first + i]), 32'(e[i]));
      else chk({name, "_missing"}, 32'(cap_d.size()), 32'(first + i + 1));
    end
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.out_ready = 1'b0;
`ifdef MEM_STREAM_STRIDE_EN
    bus.stride    = '0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    clear_stats();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.read_addr), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // basic stream, full throughput
    clear_stats();
    n = cyc;
    issue(16, 4, 1);
    wait_done(20);
    @(negedge clk); #1;
    chk("basic_first_valid", first_valid_cyc, n + 2);
    chk("basic_done_cyc", done_cyc, n + 6);
    chk("basic_beats", beats, 4);
    chk("basic_done_cnt", done_cnt, 1);
    chk_words("basic_word", 0, 16'h30, 16'h33, 16'h36);
    chk_words("basic_tail", 1, 16'h33, 16'h36, 16'h39);
    if (cap_l.size() == 4) begin
      chk("basic_last3", 32'(cap_l[3]), 32'd1);
      chk("basic_last0", 32'(cap_l[0]), 32'd0);
    end

    // backpressure
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    pidx = 0;
    rdy_toggle = 1'b1;
    issue(16, 4, 1);
    wait_done(40);
    @(negedge clk); #1;
    rdy_toggle = 1'b0;
    chk("bp_beats", beats, 4);
    chk("bp_done_cnt", done_cnt, 1);
    chk_words("bp_word", 1, 16'h33, 16'h36, 16'h39);

    // address wrap
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    issue(254, 3, 1);
    wait_done(20);
    @(negedge clk); #1;
    chk("wrap_beats", beats, 3);
    chk_words("wrap_word", 0, 16'h2FA, 16'h2FD, 16'h000);

    // full length with wrap
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    issue(128, 256, 1);
    wait_done(400);
    @(negedge clk); #1;
    chk("full_beats", beats, 256);
    chk("full_done_cnt", done_cnt, 1);
    if (cap_d.size() == 256) begin
      chk("full_first", 32'(cap_d[0]), 32'h180);
      chk("full_final", 32'(cap_d[255]), 32'h17D);
      chk("full_last", 32'(cap_l[255]), 32'd1);
    end

    // zero length
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    n = cyc;
    issue(5, 0, 1);
    wait_done(5);
    @(negedge clk); #1;
    repeat (3) @(negedge clk);
    #1;
    chk("zero_done_cyc", done_cyc, n + 1);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_busy_seen", 32'(busy_seen), 32'd0);
    chk("zero_valid_seen", first_valid_cyc, -1);

    // start while busy, then back-to-back command on the done cycle
    @(posedge clk);
    #1;
    clear_stats();
    issue(32, 8, 1);
    repeat (3) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = 8'h50;
    bus.length    = 9'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(30);
    chk("busy_beats", beats, 8);
    if (cap_d.size() == 8) begin
      chk("busy_first", 32'(cap_d[0]), 32'h60);
      chk("busy_final", 32'(cap_d[7]), 32'h75);
    end
    issue(0, 2, 1);
    wait_done(20);
    @(negedge clk); #1;
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_beats", beats, 10);
    if (cap_d.size() == 10) chk("b2b_word", 32'(cap_d[9]), 32'h3);

`ifdef MEM_STREAM_STRIDE_EN
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    issue(2, 3, 3);
    wait_done(20);
    @(negedge clk); #1;
    chk_words("stride_word", 0, 16'd6, 16'd15, 16'd24);
    @(posedge clk);
    #1;
    clear_stats();
    issue(2, 2, 0);
    wait_done(20);
    @(negedge clk); #1;
    chk("stride0_beats", beats, 2);
    if (cap_d.size() == 2) chk("stride0_word", 32'(cap_d[1]), 32'd6);
    cmd_stride = 1;
`endif

    // asynchronous reset mid-command
    repeat (2) @(posedge clk);
    #1;
    clear_stats();
    issue(64, 8, 1);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_addr", 32'(bus.read_addr), 32'd0);
    chk("arst_data", 32'(bus.out_data), 32'd0);
    chk("arst_last", 32'(bus.out_last), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_addr", 32'(bus.read_addr), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("post_rst_no_done", done_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
    $finish;
  end
endmodule

// File: doc/mem_read_streamer.md
Name: mem_read_streamer

Overview:
Read-side sequencer for the dual-port weight/activation Memory block. On a start command it walks a contiguous region of the memory's read port (combinational read). It registers each word into a one-entry output stage and presents it downstream as a valid/ready stream with a last-beat flag. It sits between Memory and the MAC/accumulator datapath, and absorbs downstream backpressure without losing or duplicating words.

Parameters:
DEPTH, 8, address width of the attached Memory (2**DEPTH words)
BIT_SIZE, 16, word width of the attached Memory

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  command strobe; sampled only in IDLE
base_addr  in  DEPTH  first word address, sampled with start
length  in  DEPTH+1  word count, 0..2**DEPTH, sampled with start
read_addr  out  DEPTH  drives Memory read_addr
read_data  in  BIT_SIZE  Memory data_out (valid same cycle as read_addr)
out_data  out  BIT_SIZE  stream word
out_valid  out  1  stream word valid
out_ready  in  1  downstream accepts word
out_last  out  1  marks final word of the command
busy  out  1  high in STREAM or FLUSH
done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset values (async, rst_n=0): state=IDLE; read_addr=0; remaining=0; out_data=0; out_valid=0; out_last=0; busy=0; done=0.
- States are IDLE, STREAM and FLUSH. busy = (state != IDLE).
- IDLE:
  - start=1 and length>0: latch read_addr<=base_addr and remaining<=length, then go to STREAM.
  - start=1 and length=0: stay in IDLE, done=1 next cycle, no beats produced.
- STREAM, load condition = remaining>0 and (!out_valid or out_ready). On load:
  - out_data<=read_data; out_valid<=1; out_last<=(remaining==1).
  - read_addr<=read_addr+1, wrapping modulo 2**DEPTH (0xFF -> 0x00 for DEPTH=8).
  - remaining<=remaining-1.
  - When the load sets remaining to 0, go to FLUSH.
- FLUSH: holds the last word. When out_valid and out_ready are both high, clear out_valid and out_last, go to IDLE, and pulse done=1 the following cycle (done is registered).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and read_addr hold. No word is skipped or repeated. Full throughput is 1 word/cycle with out_ready held high.
- Latency: start accepted in cycle N; read_addr=base_addr in N+1; first out_valid in N+2.
- Beat-to-done: the last handshake in cycle M gives done=1 in M+1, busy=0 from M+1. A new start is accepted in M+1.
- start while busy: ignored; no effect on the command in flight.
- out_ready without out_valid: ignored.
- out_valid, once asserted, stays high until handshake.
- Memory writes to the region being streamed are not hazard-checked. The word captured is whatever read_data shows at the load edge.
- Reset mid-command: all state returns to reset values immediately; no done pulse.

Optional Feature:
- Macro: MEM_STREAM_STRIDE_EN.
- Defined: adds input port stride (DEPTH bits), sampled with start. Each load advances read_addr<=read_addr+stride, modulo 2**DEPTH. stride=0 re-reads base_addr length times.
- Undefined: no stride port; the increment is fixed at 1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 mid-stream, asynchronously -> all outputs 0 without a clock edge; after release, idle with read_addr=0.
- Basic stream: memory[i]=i*3; start with base=0x10, length=4, out_ready=1 -> out_valid cycles N+2..N+5, data 0x30,0x33,0x36,0x39; out_last on 4th beat; done at N+6.
- Backpressure: same command, out_ready toggling 1,0,0,1,0,1,... -> exactly 4 beats in order; data stable while stalled; read_addr does not advance during stalls.
- Wrap and full length (DEPTH=8):
  - base=0xFE, length=3 -> read_addr sequence 0xFE,0xFF,0x00; data from those addresses.
  - length=256 -> 256 beats, done once.
- Zero length / start while busy:
  - length=0 -> done pulse at N+1, busy never high, out_valid never high.
  - start pulsed during an active 8-word command -> still 8 beats, single done.
- MEM_STREAM_STRIDE_EN: base=2, stride=3, length=3 -> addresses 2,5,8; stride=0, length=2 -> memory[2] twice.
